inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Instruction-fetch controller upstream of the decode/execute datapath.
- Holds the architectural fetch PC and issues one read request per instruction to the instruction memory over a valid/ready read-address/read-data channel pair.
- Delivers {inst, inst_pc} to decode over a valid/ready handshake, then waits for the next PC from execute before fetching again.
- Single-issue, one instruction in flight; detects misaligned-PC, bus-error and memory-timeout faults.

Parameters:
- RESET_PC, 32'h80000000, PC fetched first after reset.
- TIMEOUT, 256, cycles in WAIT_R without rvalid before a timeout fault; legal range 2..65535.
- CNT_W, 32, width of retired-fetch counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  32  next PC from execute.
- pc_in_valid  input  1  pc_in valid.
- pc_in_ready  output  1  controller accepts pc_in.
- imem_araddr  output  32  fetch address.
- imem_arvalid  output  1  address request valid.
- imem_arready  input  1  memory accepts address.
- imem_rdata  input  32  returned instruction word.
- imem_rresp  input  2  response code; 2'b00 = OKAY, anything else is an error.
- imem_rvalid  input  1  read data valid.
- imem_rready  output  1  controller accepts read data.
- inst  output  32  fetched instruction to decode.
- inst_pc  output  32  PC of inst; faulting PC while in FAULT.
- inst_valid  output  1  inst/inst_pc valid.
- inst_ready  input  1  decode accepts the instruction.
- fetch_fault  output  1  high while in FAULT.
- fault_cause  output  2  01 misaligned, 10 bus error, 11 timeout, 00 none.
- fetch_cnt  output  CNT_W  count of completed inst handshakes.

Behaviour:
- States: BOOT, REQ, WAIT_R, OUT, WAIT_PC, FAULT. All state updates on the clk rising edge.
- Reset (rst=1 at an edge):
  - state=BOOT, pc_q=RESET_PC, inst=0, fetch_cnt=0, fault_cause=00, timeout counter=0.
  - Reset overrides any transaction in progress. No handshake completes on a reset edge.
- Output decode:
  - imem_arvalid=(state==REQ); imem_rready=(state==WAIT_R); inst_valid=(state==OUT); pc_in_ready=(state==WAIT_PC); fetch_fault=(state==FAULT).
  - All of these are 0 in BOOT.
  - imem_araddr=pc_q and inst_pc=pc_q at all times, so both hold 32'h80000000 from the first edge of reset.
- BOOT -> REQ unconditionally on the next edge. The first arvalid therefore appears 2 cycles after rst falls.
- REQ:
  - Hold arvalid and araddr stable until imem_arready=1.
  - On the handshake edge -> WAIT_R and clear the timeout counter.
- WAIT_R:
  - rvalid=1 and rresp==00: inst<=rdata, -> OUT.
  - rvalid=1 and rresp!=00: fault_cause<=10, -> FAULT. inst is unchanged.
  - rvalid=0: counter increments. When the counter==TIMEOUT-1 and rvalid=0: fault_cause<=11, -> FAULT.
  - rvalid in that same final cycle wins over timeout.
- OUT:
  - inst and inst_pc held stable while inst_valid=1.
  - On inst_ready=1: fetch_cnt+=1 (wraps modulo 2^CNT_W), -> WAIT_PC.
- WAIT_PC:
  - On pc_in_valid=1: pc_q<=pc_in.
  - If pc_in[1:0]!=00: fault_cause<=01, -> FAULT, and no memory request is issued. Otherwise -> REQ.
- FAULT:
  - Terminal until rst. All handshake outputs are 0.
  - inst_pc shows the faulting PC; fault_cause is held.
  - Late rvalid is ignored because rready=0.
- Latency:
  - With zero-wait partners, one instruction takes 4 cycles: REQ, WAIT_R, OUT, WAIT_PC.
  - Each cycle a partner withholds ready or valid adds exactly 1 cycle.
- Ready/valid inputs arriving in a state that does not sample them are ignored. The controller never asserts two handshake outputs simultaneously.

Test Plan:
- Reset release, memory always ready, rdata=32'h00000413 after 0 wait, inst_ready=1, pc_in=32'h80000004 valid → araddr=80000000 at cycle 2; inst_valid on cycle 4 with inst=00000413 and inst_pc=80000000; next arvalid with araddr=80000004 on cycle 6; fetch_cnt=1.
- Backpressure: arready low 3 cycles, rvalid after 5 cycles, inst_ready low 2 cycles → araddr and inst stable throughout; each stall adds exactly its cycles; fetch_cnt increments once.
- pc_in=32'h80000006 in WAIT_PC → FAULT next edge; fault_cause=01, inst_pc=80000006, no further arvalid.
- rvalid with rresp=2'b10 → FAULT, fault_cause=10, inst_valid never asserted. Then pulse rst → arvalid re-asserts with araddr=80000000.
- TIMEOUT=4, rvalid never → FAULT entered on the 4th WAIT_R edge, fault_cause=11. Repeat with rvalid on the 4th cycle → OUT, no fault.
- rst asserted in WAIT_R with a later rvalid → returns via BOOT; the stale rvalid is ignored; fetch_cnt=0; refetch from 80000000.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, instruction memory, decode and execute.
// The controller side takes the master modport; the environment side takes slave.
interface inst_fetch_ctrl_if;
    logic [31:0] pc_in;
    logic        pc_in_valid;
    logic        pc_in_ready;

    logic [31:0] imem_araddr;
    logic        imem_arvalid;
    logic        imem_arready;

    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rvalid;
    logic        imem_rready;

    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    modport master (
        input  pc_in, pc_in_valid, imem_arready, imem_rdata, imem_rresp, imem_rvalid, inst_ready,
        output pc_in_ready, imem_araddr, imem_arvalid, imem_rready, inst, inst_pc, inst_valid
    );

    modport slave (
        output pc_in, pc_in_valid, imem_arready, imem_rdata, imem_rresp, imem_rvalid, inst_ready,
        input  pc_in_ready, imem_araddr, imem_arvalid, imem_rready, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Single-issue instruction-fetch controller: one memory read per instruction, one
// instruction in flight, terminal FAULT on misaligned PC, bus error or memory timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   BOOT    | first cycle after reset, no outputs asserted
//   REQ     | imem_arvalid high with araddr = pc_q, waiting for arready
//   WAIT_R  | imem_rready high, timeout counter running
//   OUT     | inst_valid high, waiting for decode
//   WAIT_PC | pc_in_ready high, waiting for next PC from execute
//   FAULT   | terminal until reset, cause in fault_cause
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 256,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_ctrl_if.master    bus,
    output logic                 fetch_fault,
    output logic [1:0]           fault_cause,
    output logic [CNT_W-1:0]     fetch_cnt
);

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        REQ     = 3'd1,
        WAIT_R  = 3'd2,
        OUT     = 3'd3,
        WAIT_PC = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b11;
    localparam logic [15:0] TO_LAST        = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [15:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            fetch_cnt   <= '0;
            fault_cause <= 2'b00;
            to_cnt      <= '0;
        end else begin
            unique case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (bus.imem_arready) begin
                        to_cnt <= '0;
                        state  <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    // A response in the final cycle beats the timeout.
                    if (bus.imem_rvalid) begin
                        if (bus.imem_rresp == 2'b00) begin
                            inst_q <= bus.imem_rdata;
                            state  <= OUT;
                        end else begin
                            fault_cause <= CAUSE_BUS_ERR;
                            state       <= FAULT;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        fault_cause <= CAUSE_TIMEOUT;
                        state       <= FAULT;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                OUT: begin
                    if (bus.inst_ready) begin
                        fetch_cnt <= fetch_cnt + CNT_W'(1);
                        state     <= WAIT_PC;
                    end
                end
                WAIT_PC: begin
                    // pc_q takes the new PC even when misaligned so FAULT reports it.
                    if (bus.pc_in_valid) begin
                        pc_q <= bus.pc_in;
                        if (bus.pc_in[1:0] != 2'b00) begin
                            fault_cause <= CAUSE_MISALIGN;
                            state       <= FAULT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                FAULT: state <= FAULT;
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.imem_arvalid = (state == REQ);
    assign bus.imem_rready  = (state == WAIT_R);
    assign bus.inst_valid   = (state == OUT);
    assign bus.pc_in_ready  = (state == WAIT_PC);
    assign fetch_fault      = (state == FAULT);

    assign bus.imem_araddr  = pc_q;
    assign bus.inst_pc      = pc_q;
    assign bus.inst         = inst_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: the driver plays memory, decode and execute with
// random stalls and queues the expected handshake sequence; a monitor checks it.
module tb_inst_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 6;
    localparam int          CW     = 32;

    localparam int EV_AR = 0, EV_R = 1, EV_INST = 2, EV_PC = 3, EV_FAULT = 4;
    localparam int PH_AR = 0, PH_R = 1, PH_O = 2, PH_P = 3, PH_ANY = 4;

    typedef struct {
        int          kind;
        int          gap;
        logic [31:0] a;
        logic [31:0] pc;
        logic [CW-1:0] cnt;
        logic [1:0]  cause;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_fault;
    logic [1:0]    fault_cause;
    logic [CW-1:0] fetch_cnt;

    inst_fetch_ctrl_if bus();

    inst_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fetch_fault(fetch_fault),
        .fault_cause(fault_cause),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    ev_t evq[$];

    // Reference model state
    logic [31:0]   m_pc;
    logic [31:0]   m_inst;
    logic [CW-1:0] m_cnt;
    bit            after_rst;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic ev_t mk(input int k, input int g, input logic [31:0] a, input logic [31:0] pc,
                               input logic [CW-1:0] cnt, input logic [1:0] cause);
        ev_t e;
        e.kind = k; e.gap = g; e.a = a; e.pc = pc; e.cnt = cnt; e.cause = cause;
        return e;
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_AR:   return "ar";
            EV_R:    return "r";
            EV_INST: return "inst";
            EV_PC:   return "pc";
            default: return "fault";
        endcase
    endfunction

    // ---------------- monitor ----------------
    int          last_evt = 0;
    bit          in_fault = 0;
    logic [1:0]  f_cause;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    ev_t         mon_e;
    int          mon_k;
    int          mon_n;

    always @(negedge clk) begin
        if (rst) begin
            last_evt = cyc + 1;
            in_fault = 0;
        end else begin
            mon_n = int'(bus.imem_arvalid) + int'(bus.imem_rready) + int'(bus.inst_valid)
                  + int'(bus.pc_in_ready) + int'(fetch_fault);
            chk("single_output", 64'(mon_n <= 1), 64'd1);

            if (fetch_fault && !in_fault) begin
                chk("fault_expected", 64'(evq.size() != 0 && evq[0].kind == EV_FAULT), 64'd1);
                if (evq.size() != 0 && evq[0].kind == EV_FAULT) begin
                    mon_e = evq.pop_front();
                    chk("fault_gap", 64'(cyc - last_evt), 64'(mon_e.gap));
                    chk("fault_cause", 64'(fault_cause), 64'(mon_e.cause));
                    chk("fault_pc", 64'(bus.inst_pc), 64'(mon_e.pc));
                    f_cause = mon_e.cause; f_pc = mon_e.pc; f_inst = mon_e.a;
                end
                in_fault = 1;
            end else if (in_fault) begin
                chk("fault_hold", {fault_cause, bus.inst_pc, bus.inst}, {f_cause, f_pc, f_inst});
            end

            if (bus.imem_arvalid && evq.size() != 0 && evq[0].kind == EV_AR)
                chk("araddr_stable", 64'(bus.imem_araddr), 64'(evq[0].a));
            if (bus.inst_valid && evq.size() != 0 && evq[0].kind == EV_INST)
                chk("inst_stable", {bus.inst, bus.inst_pc}, {evq[0].a, evq[0].pc});

            mon_k = -1;
            if (bus.imem_arvalid && bus.imem_arready)     mon_k = EV_AR;
            else if (bus.imem_rready && bus.imem_rvalid)  mon_k = EV_R;
            else if (bus.inst_valid && bus.inst_ready)    mon_k = EV_INST;
            else if (bus.pc_in_ready && bus.pc_in_valid)  mon_k = EV_PC;

            if (mon_k >= 0) begin
                chk("hs_expected", 64'(evq.size() != 0), 64'd1);
                if (evq.size() != 0) begin
                    mon_e = evq.pop_front();
                    chk({kname(mon_k), "_kind"}, 64'(mon_k), 64'(mon_e.kind));
                    chk({kname(mon_k), "_gap"}, 64'(cyc + 1 - last_evt), 64'(mon_e.gap));
                    if (mon_e.kind == EV_INST)
                        chk("fetch_cnt_at_hs", 64'(fetch_cnt), 64'(mon_e.cnt));
                end
                last_evt = cyc + 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic clr();
        bus.pc_in        = '0;
        bus.pc_in_valid  = 1'b0;
        bus.imem_arready = 1'b0;
        bus.imem_rdata   = '0;
        bus.imem_rresp   = 2'b00;
        bus.imem_rvalid  = 1'b0;
        bus.inst_ready   = 1'b0;
    endtask

    // Random activity on every channel the current state does not sample.
    task automatic junk(input int ph);
        bus.pc_in        = $urandom();
        bus.imem_rdata   = $urandom();
        bus.imem_rresp   = 2'($urandom_range(0, 3));
        bus.imem_arready = (ph == PH_AR) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.imem_rvalid  = (ph == PH_R)  ? 1'b0 : 1'($urandom_range(0, 1));
        bus.inst_ready   = (ph == PH_O)  ? 1'b0 : 1'($urandom_range(0, 1));
        bus.pc_in_valid  = (ph == PH_P)  ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic step(input int ph);
        junk(ph);
        @(posedge clk); #1;
    endtask

    task automatic wait_sig(input int which, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            case (which)
                0:       ok = bus.imem_arvalid;
                1:       ok = bus.imem_rready;
                2:       ok = bus.inst_valid;
                default: ok = bus.pc_in_ready;
            endcase
            if (ok) break;
            @(posedge clk); #1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic do_reset(input int n, input bit stale);
        chk("queue_drained", 64'(evq.size()), 64'd0);
        rst = 1'b1;
        clr();
        if (stale) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        repeat (n) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.imem_arvalid, bus.imem_rready, bus.inst_valid, bus.pc_in_ready, fetch_fault}, 64'd0);
        chk("rst_pc", {bus.imem_araddr, bus.inst_pc}, {RST_PC, RST_PC});
        chk("rst_inst", 64'(bus.inst), 64'd0);
        chk("rst_cnt_cause", {fetch_cnt, fault_cause}, 64'd0);
        evq.delete();
        m_pc = RST_PC; m_inst = '0; m_cnt = '0; after_rst = 1;
        rst = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] word, input logic [1:0] resp, input int a, input int r,
                             input int d, input int p, input logic [31:0] npc, input bit tmo,
                             output bit cont);
        bit ok;
        cont = 0;
        evq.push_back(mk(EV_AR, (after_rst ? 2 : 1) + a, m_pc, m_pc, '0, 2'b00));
        after_rst = 0;
        wait_sig(0, "wait_arvalid", ok);
        if (!ok) return;
        repeat (a) step(PH_AR);
        clr(); bus.imem_arready = 1'b1;
        @(posedge clk); #1;
        bus.imem_arready = 1'b0;

        if (tmo) begin
            evq.push_back(mk(EV_FAULT, TO, m_inst, m_pc, '0, 2'b11));
            repeat (TO + 3) step(PH_R);
            repeat (4) step(PH_ANY);
            clr();
            return;
        end

        wait_sig(1, "wait_rready", ok);
        if (!ok) return;
        evq.push_back(mk(EV_R, 1 + r, word, m_pc, '0, 2'b00));
        repeat (r) step(PH_R);
        clr();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word; bus.imem_rresp = resp;
        if (resp != 2'b00) evq.push_back(mk(EV_FAULT, 0, m_inst, m_pc, '0, 2'b10));
        @(posedge clk); #1;
        bus.imem_rvalid = 1'b0;
        if (resp != 2'b00) begin
            repeat (6) step(PH_ANY);
            clr();
            return;
        end
        m_inst = word;

        evq.push_back(mk(EV_INST, 1 + d, word, m_pc, m_cnt, 2'b00));
        wait_sig(2, "wait_inst_valid", ok);
        if (!ok) return;
        repeat (d) step(PH_O);
        clr(); bus.inst_ready = 1'b1;
        @(posedge clk); #1;
        bus.inst_ready = 1'b0;
        m_cnt = m_cnt + CW'(1);
        chk("fetch_cnt_after", 64'(fetch_cnt), 64'(m_cnt));

        evq.push_back(mk(EV_PC, 1 + p, npc, npc, '0, 2'b00));
        wait_sig(3, "wait_pc_in_ready", ok);
        if (!ok) return;
        repeat (p) step(PH_P);
        clr(); bus.pc_in = npc; bus.pc_in_valid = 1'b1;
        if (npc[1:0] != 2'b00) evq.push_back(mk(EV_FAULT, 0, m_inst, npc, '0, 2'b01));
        @(posedge clk); #1;
        bus.pc_in_valid = 1'b0;
        m_pc = npc;
        if (npc[1:0] != 2'b00) begin
            repeat (6) step(PH_ANY);
            clr();
            return;
        end
        cont = 1;
    endtask

    initial begin
        bit ok;
        bit cont;
        int n;
        logic [1:0]  resp;
        bit          tmo;
        logic [31:0] npc;
        logic [31:0] word;

        clr();
        do_reset(3, 0);

        // zero-wait fetch, then backpressure on every channel, then misaligned next PC
        fetch_one(32'h0000_0413, 2'b00, 0, 0, 0, 0, 32'h8000_0004, 0, cont);
        fetch_one(32'h00a0_0093, 2'b00, 3, 5, 2, 1, 32'h8000_0010, 0, cont);
        fetch_one(32'h1234_5678, 2'b00, 0, 0, 0, 0, 32'h8000_0006, 0, cont);

        do_reset(2, 0);
        fetch_one(32'hCAFE_F00D, 2'b10, 1, 2, 0, 0, 32'h0, 0, cont);

        do_reset(2, 0);
        fetch_one(32'h0, 2'b00, 0, 0, 0, 0, 32'h0, 1, cont);

        do_reset(2, 0);
        fetch_one(32'h0010_0093, 2'b00, 0, TO - 1, 0, 0, 32'h8000_0008, 0, cont);
        fetch_one(32'h0020_0113, 2'b00, 0, 0, 0, 0, 32'h8000_000C, 0, cont);

        // reset in WAIT_R with a late response
        do_reset(2, 0);
        evq.push_back(mk(EV_AR, 2, RST_PC, RST_PC, '0, 2'b00));
        after_rst = 0;
        wait_sig(0, "wait_arvalid", ok);
        clr(); bus.imem_arready = 1'b1;
        @(posedge clk); #1;
        bus.imem_arready = 1'b0;
        wait_sig(1, "wait_rready", ok);
        repeat (2) @(posedge clk);
        #1;
        do_reset(2, 1);
        fetch_one(32'h0010_0073, 2'b00, 1, 0, 0, 0, 32'h8000_0100, 0, cont);

        for (int ep = 0; ep < 12; ep++) begin
            do_reset($urandom_range(1, 3), 0);
            n = $urandom_range(3, 12);
            cont = 1;
            for (int i = 0; i < n && cont; i++) begin
                resp = 2'b00;
                tmo  = 0;
                word = $urandom();
                npc  = $urandom() & 32'hFFFF_FFFC;
                if (i == n - 1) begin
                    case ($urandom_range(0, 4))
                        0: resp = 2'($urandom_range(1, 3));
                        1: tmo = 1;
                        2: npc = npc | 32'($urandom_range(1, 3));
                        default: ;
                    endcase
                end
                fetch_one(word, resp, $urandom_range(0, 3), $urandom_range(0, TO - 1),
                          $urandom_range(0, 3), $urandom_range(0, 3), npc, tmo, cont);
            end
        end

        do_reset(2, 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        repeat (40000) @(posedge clk);
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: run still active at cycle %0d, limit 40000", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
